// File: rtl/serial_add_sequencer_if.sv
// Requester handshake plus the link to the shared external half adder.
// slave is the sequencer's view; master is the environment (requester and half adder).
interface serial_add_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ha_a;
    logic             ha_b;
    logic             ha_sum;
    logic             ha_carry;

    modport master (
        output start, a, b, cin, ha_sum, ha_carry,
        input  busy, done, sum, cout, ha_a, ha_b
    );

    modport slave (
        input  start, a, b, cin, ha_sum, ha_carry,
        output busy, done, sum, cout, ha_a, ha_b
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: one external half adder is time-shared as a full adder,
// two cycles per bit (P0 forms a^b, P1 folds in the running carry).
module serial_add_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_add_sequencer_if.slave bus
);
    localparam int unsigned   IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StP0, StP1, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_p;
    logic             r_g;
    logic             r_cout;
    logic [IW-1:0]    r_i;
    logic [WIDTH-1:0] w_mask;
    logic             w_last;
    logic             w_carry;
    logic             w_ha_a;
    logic             w_ha_b;
    logic             w_busy;
    logic             w_done;

    // One-hot select of the current bit keeps indexing width-safe down to WIDTH=1.
    assign w_mask  = WIDTH'(1) << r_i;
    assign w_last  = (r_i == LAST);
    assign w_carry = r_g | bus.ha_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.start) w_state_next = StP0;
            StP0:    w_state_next = StP1;
            StP1:    w_state_next = w_last ? StDone : StP0;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_ha_a = 1'b0;
        w_ha_b = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            StP0: begin
                w_ha_a = |(r_ra & w_mask);
                w_ha_b = |(r_rb & w_mask);
                w_busy = 1'b1;
            end
            StP1: begin
                w_ha_a = r_p;
                w_ha_b = r_c;
                w_busy = 1'b1;
            end
            StDone:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra   <= '0;
            r_rb   <= '0;
            r_sum  <= '0;
            r_c    <= 1'b0;
            r_p    <= 1'b0;
            r_g    <= 1'b0;
            r_cout <= 1'b0;
            r_i    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_ra   <= bus.a;
                        r_rb   <= bus.b;
                        r_c    <= bus.cin;
                        r_sum  <= '0;
                        r_cout <= 1'b0;
                        r_i    <= '0;
                    end
                end
                StP0: begin
                    r_p <= bus.ha_sum;
                    r_g <= bus.ha_carry;
                end
                StP1: begin
                    r_sum <= bus.ha_sum ? (r_sum | w_mask) : (r_sum & ~w_mask);
                    r_c   <= w_carry;
                    if (w_last) begin
                        r_cout <= w_carry;
                    end else begin
                        r_i <= r_i + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ha_a = w_ha_a;
    assign bus.ha_b = w_ha_b;
    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer at WIDTH=8 and WIDTH=1, each with a behavioural
// half adder on its link; checks timing, half-adder drive sequence and results.
module tb_serial_add_sequencer;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    serial_add_sequencer_if #(.WIDTH(8)) bus8 ();
    serial_add_sequencer_if #(.WIDTH(1)) bus1 ();

    serial_add_sequencer #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_add_sequencer #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    assign bus8.ha_sum   = bus8.ha_a ^ bus8.ha_b;
    assign bus8.ha_carry = bus8.ha_a & bus8.ha_b;
    assign bus1.ha_sum   = bus1.ha_a ^ bus1.ha_b;
    assign bus1.ha_carry = bus1.ha_a & bus1.ha_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pulse_k: -1 none, 0..15 extra start during that busy cycle, 16 extra start during DONE.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input int pulse_k, input string tag);
        logic       c;
        logic       p;
        logic [8:0] exp;
        int         i;
        exp = {1'b0, a} + {1'b0, b} + {8'b0, cin};
        @(negedge clk);
        bus8.a = a;
        bus8.b = b;
        bus8.cin = cin;
        bus8.start = 1'b1;
        c = cin;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            i = k / 2;
            p = a[i] ^ b[i];
            check_eq({tag, " busy"}, {31'b0, bus8.busy}, 32'd1);
            check_eq({tag, " done_low"}, {31'b0, bus8.done}, 32'd0);
            if (k % 2 == 0) begin
                check_eq({tag, " p0_ha_a"}, {31'b0, bus8.ha_a}, {31'b0, a[i]});
                check_eq({tag, " p0_ha_b"}, {31'b0, bus8.ha_b}, {31'b0, b[i]});
            end else begin
                check_eq({tag, " p1_ha_a"}, {31'b0, bus8.ha_a}, {31'b0, p});
                check_eq({tag, " p1_ha_b"}, {31'b0, bus8.ha_b}, {31'b0, c});
                c = (a[i] & b[i]) | (p & c);
            end
            if (k == pulse_k) begin
                bus8.a = ~a;
                bus8.b = ~b;
                bus8.cin = ~cin;
                bus8.start = 1'b1;
            end
        end
        @(negedge clk);
        bus8.start = 1'b0;
        check_eq({tag, " done"}, {31'b0, bus8.done}, 32'd1);
        check_eq({tag, " busy_in_done"}, {31'b0, bus8.busy}, 32'd0);
        check_eq({tag, " ha_in_done"}, {30'b0, bus8.ha_a, bus8.ha_b}, 32'd0);
        check_eq({tag, " result"}, {23'b0, bus8.cout, bus8.sum}, {23'b0, exp});
        if (pulse_k == 16) begin
            bus8.a = ~a;
            bus8.start = 1'b1;
        end
        @(negedge clk);
        bus8.start = 1'b0;
        check_eq({tag, " single_done"}, {31'b0, bus8.done}, 32'd0);
        check_eq({tag, " idle_busy"}, {31'b0, bus8.busy}, 32'd0);
        check_eq({tag, " ha_in_idle"}, {30'b0, bus8.ha_a, bus8.ha_b}, 32'd0);
        if (pulse_k >= 0) begin
            @(negedge clk);
            check_eq({tag, " no_second_op"}, {30'b0, bus8.busy, bus8.done}, 32'd0);
            check_eq({tag, " result_held"}, {23'b0, bus8.cout, bus8.sum}, {23'b0, exp});
        end
    endtask

    task automatic run1(input logic a, input logic b, input logic cin, input string tag);
        logic [1:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {1'b0, cin};
        @(negedge clk);
        bus1.a = a;
        bus1.b = b;
        bus1.cin = cin;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        check_eq({tag, " p0"}, {29'b0, bus1.busy, bus1.ha_a, bus1.ha_b}, {29'b0, 1'b1, a, b});
        @(negedge clk);
        check_eq({tag, " p1"}, {29'b0, bus1.busy, bus1.ha_a, bus1.ha_b}, {29'b0, 1'b1, a ^ b, cin});
        @(negedge clk);
        check_eq({tag, " done"}, {30'b0, bus1.busy, bus1.done}, 32'd1);
        check_eq({tag, " result"}, {30'b0, bus1.cout, bus1.sum}, {30'b0, exp});
        @(negedge clk);
        check_eq({tag, " idle"}, {30'b0, bus1.busy, bus1.done}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus8.cin = 1'b0;
        bus1.start = 1'b0;
        bus1.a = '0;
        bus1.b = '0;
        bus1.cin = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst busy_done", {30'b0, bus8.busy, bus8.done}, 32'd0);
        check_eq("rst result", {23'b0, bus8.cout, bus8.sum}, 32'd0);
        check_eq("rst ha", {30'b0, bus8.ha_a, bus8.ha_b}, 32'd0);
        check_eq("rst w1", {28'b0, bus1.busy, bus1.done, bus1.cout, bus1.sum}, 32'd0);

        run8(8'hFF, 8'h01, 1'b0, -1, "ff_01");
        run8(8'hA5, 8'h5A, 1'b1, -1, "a5_5a_c");
        run8(8'h00, 8'h00, 1'b0, -1, "zero");
        run8(8'h3C, 8'h0F, 1'b0, 3, "pulse_p1");
        run8(8'h81, 8'h7E, 1'b1, 6, "pulse_p0");
        run8(8'h12, 8'h34, 1'b0, 16, "pulse_done");

        // Abort at bit 3 with a non-zero partial sum already built.
        @(negedge clk);
        bus8.a = 8'h07;
        bus8.b = 8'h00;
        bus8.cin = 1'b0;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("abort pre_busy", {31'b0, bus8.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort busy_done", {30'b0, bus8.busy, bus8.done}, 32'd0);
        check_eq("abort result", {23'b0, bus8.cout, bus8.sum}, 32'd0);
        check_eq("abort ha", {30'b0, bus8.ha_a, bus8.ha_b}, 32'd0);
        @(negedge clk);
        check_eq("abort held", {30'b0, bus8.busy, bus8.done}, 32'd0);
        rst_n = 1'b1;
        run8(8'hC8, 8'h64, 1'b1, -1, "after_abort");

        for (int v = 0; v < 8; v++) begin
            logic [2:0] t;
            t = 3'(v);
            run1(t[2], t[1], t[0], "w1");
        end

        for (int n = 0; n < 1000; n++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), -1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
